// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: stage-three load/store request and response bundle
interface data_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall;
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array memory serving one request at a time after WAIT_CYCLES wait states
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              eff_wr, in_range, commit;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [DATA_W-1:0] mem [DEPTH];
  // In IDLE the live request fields are used so a zero-wait build can commit on the accept edge
  always_comb begin
    state_n   = state == S_IDLE ? (bus.req_valid ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE)
              : state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
    eff_wr    = state == S_IDLE ? bus.req_wr : lat_wr;
    eff_addr  = state == S_IDLE ? bus.req_addr : lat_addr;
    eff_wdata = state == S_IDLE ? bus.req_wdata : lat_wdata;
    in_range  = {1'b0, eff_addr} < (ADDR_W+1)'(DEPTH);
    commit    = state != S_RESP && state_n == S_RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.req_valid) begin
        lat_wr    <= bus.req_wr;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (commit) begin
        rdata <= (!eff_wr && in_range) ? mem[eff_addr[AW-1:0]] : '0;
        err   <= !in_range;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && commit && eff_wr && in_range) mem[eff_addr[AW-1:0]] <= eff_wdata;
  assign bus.req_ready = state == S_IDLE;
  assign bus.rsp_valid = state == S_RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign bus.stall     = bus.req_valid & ~bus.rsp_valid;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors against a 2-wait-state and a zero-wait responder
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  data_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) a ();
  data_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b ();
  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(a));
  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b));
  typedef struct {
    bit          sel;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start(input bit sel, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    if (sel) begin b.req_valid = 1'b1; b.req_wr = wr; b.req_addr = addr; b.req_wdata = wdata; end
    else begin a.req_valid = 1'b1; a.req_wr = wr; a.req_addr = addr; a.req_wdata = wdata; end
  endtask
  task automatic drop();
    a.req_valid = 1'b0;
    b.req_valid = 1'b0;
  endtask
  // Returns at the negedge of the response cycle; lat counts the non-response cycles before it
  task automatic wait_rsp(input bit sel, output int lat, output int stl,
                          output logic [15:0] rd, output logic er, output logic st);
    lat = 0;
    stl = 0;
    rd = 'x;
    er = 1'bx;
    st = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? b.rsp_valid : a.rsp_valid) begin
        rd = sel ? b.rsp_rdata : a.rsp_rdata;
        er = sel ? b.rsp_err : a.rsp_err;
        st = sel ? b.stall : a.stall;
        return;
      end
      lat++;
      stl += int'(sel ? b.stall : a.stall);
    end
    chk("rsp_timeout", 32'd1, 32'd0);
  endtask
  task automatic run(input bit sel, input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                     output logic [15:0] rd, output logic er);
    int lat, stl;
    logic st;
    start(sel, wr, addr, wdata);
    wait_rsp(sel, lat, stl, rd, er, st);
    chk($sformatf("latency_%0h", addr), lat, sel ? 1 : 3);
    chk($sformatf("stall_cycles_%0h", addr), stl, sel ? 1 : 3);
    chk($sformatf("stall_at_rsp_%0h", addr), {31'd0, st}, 0);
    @(posedge clk); #1;
    drop();
    @(posedge clk); #1;
  endtask
  initial begin
    logic [15:0] rd;
    logic er, st;
    int lat, stl;
    vecs[0]  = '{0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0};
    vecs[1]  = '{0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0};
    vecs[2]  = '{0, 1, 16'h0000, 16'h7777, 16'h0000, 0};
    vecs[3]  = '{0, 1, 16'h0100, 16'hAAAA, 16'h0000, 1};
    vecs[4]  = '{0, 1, 16'h00FF, 16'hC3C3, 16'h0000, 0};
    vecs[5]  = '{0, 0, 16'h00FF, 16'h0000, 16'hC3C3, 0};
    vecs[6]  = '{0, 0, 16'h0100, 16'h0000, 16'h0000, 1};
    vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 16'h7777, 0};
    vecs[8]  = '{0, 1, 16'h0021, 16'h3333, 16'h0000, 0};
    vecs[9]  = '{0, 1, 16'h0030, 16'h0F0F, 16'h0000, 0};
    vecs[10] = '{0, 0, 16'hFFFF, 16'h0000, 16'h0000, 1};
    vecs[11] = '{0, 0, 16'h1010, 16'h0000, 16'h0000, 1};
    vecs[12] = '{1, 1, 16'h0005, 16'h1234, 16'h0000, 0};
    vecs[13] = '{1, 0, 16'h0005, 16'h0000, 16'h1234, 0};
    a.req_valid = 1'b0; a.req_wr = 1'b0; a.req_addr = '0; a.req_wdata = '0;
    b.req_valid = 1'b0; b.req_wr = 1'b0; b.req_addr = '0; b.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, a.req_ready}, 1);
    chk("reset_rsp_valid", {31'd0, a.rsp_valid}, 0);
    chk("reset_rsp_rdata", {16'd0, a.rsp_rdata}, 0);
    chk("reset_rsp_err", {31'd0, a.rsp_err}, 0);
    chk("reset_stall", {31'd0, a.stall}, 0);
    chk("reset_b_rsp_valid", {31'd0, b.rsp_valid}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      run(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end
    // Zero-wait back-to-back: held request is re-accepted, responses 2 cycles apart
    start(1, 0, 16'h0005, 16'h0000);
    wait_rsp(1, lat, stl, rd, er, st);
    chk("b2b_first_rdata", {16'd0, rd}, 32'h1234);
    wait_rsp(1, lat, stl, rd, er, st);
    chk("b2b_spacing", lat + 1, 2);
    chk("b2b_second_rdata", {16'd0, rd}, 32'h1234);
    @(posedge clk); #1;
    drop();
    @(posedge clk); #1;
    // 2-wait back-to-back: spacing WAIT_CYCLES+2 = 4
    start(0, 0, 16'h0010, 16'h0000);
    wait_rsp(0, lat, stl, rd, er, st);
    wait_rsp(0, lat, stl, rd, er, st);
    chk("a_b2b_spacing", lat + 1, 4);
    chk("a_b2b_rdata", {16'd0, rd}, 32'hBEEF);
    @(posedge clk); #1;
    drop();
    @(posedge clk); #1;
    // Field change mid-flight
    start(0, 1, 16'h0020, 16'h1111);
    @(posedge clk); #1;
    a.req_addr = 16'h0021;
    a.req_wdata = 16'h2222;
    wait_rsp(0, lat, stl, rd, er, st);
    chk("midflight_lat", lat, 2);
    @(posedge clk); #1;
    drop();
    @(posedge clk); #1;
    run(0, 0, 16'h0020, 16'h0000, rd, er);
    chk("midflight_word20", {16'd0, rd}, 32'h1111);
    run(0, 0, 16'h0021, 16'h0000, rd, er);
    chk("midflight_word21", {16'd0, rd}, 32'h3333);
    // Reset on the edge that would otherwise commit the store
    start(0, 1, 16'h0030, 16'h5A5A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drop();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, a.req_ready}, 1);
    chk("rst_mid_rsp_valid", {31'd0, a.rsp_valid}, 0);
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lat += int'(a.rsp_valid);
    end
    chk("rst_mid_no_rsp", lat, 0);
    @(posedge clk); #1;
    run(0, 0, 16'h0030, 16'h0000, rd, er);
    chk("rst_mid_word30", {16'd0, rd}, 32'h0F0F);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
